scrambler_frame_ctrl: RTL

Frame-level controller and datapath for the 8-bit additive scrambler. It latches a seed and a frame length on a start command, then seeds the LFSR. It XORs each accepted input byte with the current LFSR state, advances the LFSR once per accepted byte, and closes the frame with a last flag and a done pulse. It sits between the byte source and the line encoder, with valid/ready handshakes on both sides.

---
 rtl/scrambler_frame_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/scrambler_frame_ctrl.sv
// Frame controller + datapath for the 8-bit additive scrambler: seed on start, XOR each byte with the LFSR, tag last, pulse done.
// Latency: accepted byte appears on m_data the next cycle; a stalled output holds its byte and blocks s_ready.
module scrambler_frame_ctrl #(
    parameter int          LEN_W        = 16,
    parameter logic [7:0]  DEFAULT_SEED = 8'h01
) (
    input  logic             clk2,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       cfg_seed,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             s_valid,
    input  logic [7:0]       s_data,
    output logic             s_ready,
    output logic             m_valid,
    output logic [7:0]       m_data,
    output logic             m_last,
    input  logic             m_ready,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEED  = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       lfsr_q, lfsr_d;
    logic [7:0]       seed_q, seed_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic             m_valid_q, m_valid_d;
    logic [7:0]       m_data_q, m_data_d;
    logic             m_last_q, m_last_d;
    logic             done_q, done_d;

    logic             start_ok;
    logic             accept;
    logic             out_hs;
    logic             last_byte;
    logic [7:0]       lfsr_next;

    assign start_ok  = start && (cfg_len != '0);
    assign accept    = (state_q == RUN) && s_valid && s_ready;
    assign out_hs    = m_valid_q && m_ready;
    assign last_byte = (remaining_q == LEN_W'(1));
    assign lfsr_next = {lfsr_q[6:0], lfsr_q[1] ^ lfsr_q[3] ^ lfsr_q[4] ^ lfsr_q[6]};

    // State register
    always_ff @(posedge clk2) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = SEED;
            SEED:    state_d = RUN;
            RUN:     if (accept && last_byte) state_d = FLUSH;
            FLUSH:   if (out_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs; rst gates the combinational flags so they are low for the whole reset
    always_comb begin
        s_ready = !rst && (state_q == RUN) && (!m_valid_q || m_ready) && (remaining_q != '0);
        busy    = !rst && (state_q != IDLE);
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_last  = m_last_q;
    assign done    = done_q;

    // Datapath next values
    always_comb begin
        lfsr_d      = lfsr_q;
        seed_d      = seed_q;
        remaining_d = remaining_q;
        m_valid_d   = m_valid_q;
        m_data_d    = m_data_q;
        m_last_d    = m_last_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    remaining_d = cfg_len;
                    seed_d      = (cfg_seed == 8'h00) ? DEFAULT_SEED : cfg_seed;
                end
            end
            SEED: begin
                lfsr_d = seed_q;
            end
            RUN: begin
                if (accept) begin
                    m_data_d    = s_data ^ lfsr_q;
                    m_valid_d   = 1'b1;
                    m_last_d    = last_byte;
                    lfsr_d      = lfsr_next;
                    remaining_d = remaining_q - LEN_W'(1);
                end else if (out_hs) begin
                    m_valid_d = 1'b0;
                end
            end
            FLUSH: begin
                if (out_hs) begin
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                    done_d    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk2) begin
        if (rst) begin
            lfsr_q      <= DEFAULT_SEED;
            seed_q      <= DEFAULT_SEED;
            remaining_q <= '0;
            m_valid_q   <= 1'b0;
            m_data_q    <= 8'h00;
            m_last_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            lfsr_q      <= lfsr_d;
            seed_q      <= seed_d;
            remaining_q <= remaining_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            m_last_q    <= m_last_d;
            done_q      <= done_d;
        end
    end

endmodule
